sm_mult_sched: RTL and testbench

Two-port round-robin scheduler that shares one scalar-multiplication unit (`mult`, 256-bit affine point × scalar) between two requesters, e.g. the signing and verification engines. It latches a requester's scalar and base point, restarts and launches the unit, and waits for completion under a watchdog. It then returns the result point with a per-port done pulse. It sits between the protocol-level engines and the single `mult` instance.

---
 rtl/sm9_pkg.sv | 20 ++
 rtl/sm_mult_sched.sv | 148 ++++++++++++++
 tb/tb_sm_mult_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm9_pkg.sv
// Shared types and constants for schedulers that front the SM9 scalar-multiplication unit.
package sm9_pkg;

  localparam int          SM9_W       = 256;
  localparam logic [31:0] SM9_TIMEOUT = 32'd4_000_000;

  // Unit handshake: one-cycle active-high start, active-low reset, done as a sticky high level.
  localparam logic UNIT_EN_ACTIVE  = 1'b1;
  localparam logic UNIT_RST_ACTIVE = 1'b0;
  localparam logic UNIT_DONE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_WAIT,
    ST_RESP
  } sched_state_t;

endpackage

// File: rtl/sm_mult_sched.sv
// Round-robin scheduler sharing one scalar-multiplication unit between two requesters,
// with a per-job watchdog.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a request; arbitrates and latches operands
// ST_CLR   | unit held in reset for one cycle to clear its sticky done
// ST_START | one-cycle start pulse to the unit, watchdog cleared
// ST_WAIT  | waiting for unit done or watchdog expiry
// ST_RESP  | done pulse to the granted port, grant dropped afterwards
module sm_mult_sched
  import sm9_pkg::*;
#(
  parameter int          W       = SM9_W,
  parameter logic [31:0] TIMEOUT = SM9_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] l0,
  input  logic [W-1:0] x0_0,
  input  logic [W-1:0] y0_0,
  input  logic [W-1:0] l1,
  input  logic [W-1:0] x0_1,
  input  logic [W-1:0] y0_1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [W-1:0] rx,
  output logic [W-1:0] ry,
  output logic         u_rst_b,
  output logic         u_en,
  output logic [W-1:0] u_l,
  output logic [W-1:0] u_x0,
  output logic [W-1:0] u_y0,
  input  logic [W-1:0] u_x1,
  input  logic [W-1:0] u_y1,
  input  logic         u_sign
);

  sched_state_t state, state_nxt;
  logic [31:0]  cnt;
  logic         sel;
  logic         last;
  logic         u_rst_q;
  logic         pick;
  logic         hit;
  logic         expire;

  // On a tie the port that was not served last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic prev);
    if (r0 && r1) return !prev;
    return r1 && !r0;
  endfunction

  assign pick    = rr_pick(req0, req1, last);
  assign u_rst_b = rst_b & u_rst_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE:  if (req0 || req1) state_nxt = ST_CLR;
      ST_CLR:   state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A completion in the expiry cycle still counts as a good result.
        if (u_sign == UNIT_DONE_LEVEL) begin
          hit       = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt == TIMEOUT - 32'd1) begin
          expire    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      u_en    <= ~UNIT_EN_ACTIVE;
      u_rst_q <= ~UNIT_RST_ACTIVE;
      cnt     <= '0;
      rx      <= '0;
      ry      <= '0;
      u_l     <= '0;
      u_x0    <= '0;
      u_y0    <= '0;
    end else begin
      u_en    <= ~UNIT_EN_ACTIVE;
      u_rst_q <= ~UNIT_RST_ACTIVE;
      done0   <= 1'b0;
      done1   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            sel     <= pick;
            gnt0    <= !pick;
            gnt1    <= pick;
            u_rst_q <= UNIT_RST_ACTIVE;
            u_l     <= pick ? l1   : l0;
            u_x0    <= pick ? x0_1 : x0_0;
            u_y0    <= pick ? y0_1 : y0_0;
          end
        end
        ST_CLR:   u_en <= UNIT_EN_ACTIVE;
        ST_START: cnt  <= '0;
        ST_WAIT: begin
          cnt <= cnt + 32'd1;
          if (hit || expire) begin
            last  <= sel;
            done0 <= !sel;
            done1 <= sel;
            err   <= expire;
          end
          if (hit) begin
            rx <= u_x1;
            ry <= u_y1;
          end
        end
        ST_RESP: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_mult_sched.sv
// Directed bench for sm_mult_sched: a behavioural unit model on the main instance, and a
// hand-driven unit on a short-watchdog instance for the expiry corner cases.
module tb_sm_mult_sched;
  import sm9_pkg::*;

  localparam int W = SM9_W;
  localparam logic [W-1:0] GX  = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [W-1:0] GY  = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
  localparam logic [W-1:0] PX1 = 256'h0123456789ABCDEF00112233445566778899AABBCCDDEEFF0F1E2D3C4B5A6978;
  localparam logic [W-1:0] PY1 = 256'hFEDCBA98765432100F0E0D0C0B0A09080706050403020100A5A55A5AC3C33C3C;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] l0;
    logic [W-1:0] l1;
    int           lat;
    logic         port;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         rst_b;
  logic         req0, req1;
  logic [W-1:0] l0, l1, x0_0, y0_0, x0_1, y0_1;
  logic         gnt0, gnt1, done0, done1, err;
  logic [W-1:0] rx, ry;
  logic         u_rst_b, u_en, u_sign;
  logic [W-1:0] u_l, u_x0, u_y0, u_x1, u_y1;

  logic         req0_t, gnt0_t, gnt1_t, done0_t, done1_t, err_t, u_rst_b_t, u_en_t, u_sign_t;
  logic [W-1:0] rx_t, ry_t, u_l_t, u_x0_t, u_y0_t, u_x1_t, u_y1_t;

  sm_mult_sched #(.W(W), .TIMEOUT(32'd2000)) dut (
    .clk(clk), .rst_b(rst_b), .req0(req0), .req1(req1),
    .l0(l0), .x0_0(x0_0), .y0_0(y0_0), .l1(l1), .x0_1(x0_1), .y0_1(y0_1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .rx(rx), .ry(ry), .u_rst_b(u_rst_b), .u_en(u_en),
    .u_l(u_l), .u_x0(u_x0), .u_y0(u_y0), .u_x1(u_x1), .u_y1(u_y1), .u_sign(u_sign)
  );

  sm_mult_sched #(.W(W), .TIMEOUT(32'd64)) dut_t (
    .clk(clk), .rst_b(rst_b), .req0(req0_t), .req1(1'b0),
    .l0(l0), .x0_0(x0_0), .y0_0(y0_0), .l1(l1), .x0_1(x0_1), .y0_1(y0_1),
    .gnt0(gnt0_t), .gnt1(gnt1_t), .done0(done0_t), .done1(done1_t), .err(err_t),
    .rx(rx_t), .ry(ry_t), .u_rst_b(u_rst_b_t), .u_en(u_en_t),
    .u_l(u_l_t), .u_x0(u_x0_t), .u_y0(u_y0_t), .u_x1(u_x1_t), .u_y1(u_y1_t), .u_sign(u_sign_t)
  );

  // Cheap stand-in for the point multiplication: any operand mix-up changes the result.
  function automatic logic [W-1:0] fx(input logic [W-1:0] l, input logic [W-1:0] x);
    return x + (l << 1) + l;
  endfunction
  function automatic logic [W-1:0] fy(input logic [W-1:0] l, input logic [W-1:0] y);
    return y ^ (l << 4);
  endfunction

  // Unit model: done rises lat+1 cycles after the start cycle and sticks until unit reset.
  int   lat = 0;
  int   lc;
  logic busy;
  always @(posedge clk or negedge u_rst_b) begin
    if (!u_rst_b) begin
      u_sign <= 1'b0;
      busy   <= 1'b0;
      lc     <= 0;
      u_x1   <= '0;
      u_y1   <= '0;
    end else if (u_en) begin
      busy <= (lat != 0);
      lc   <= lat;
    end else if (busy) begin
      if (lc == 1) begin
        u_sign <= 1'b1;
        busy   <= 1'b0;
        u_x1   <= fx(u_l, u_x0);
        u_y1   <= fy(u_l, u_y0);
      end else begin
        lc <= lc - 1;
      end
    end
  end

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Runs one job on the main instance; called at a negedge, grant expected goff cycles later.
  task automatic run_vec(input vec_t v, input bit drive, input int goff, input string nm);
    int t0, g, r, e, s, d, rlow;
    bit og, gsel;
    logic dp, de;
    logic [W-1:0] drx, dry, dul, xl, xx, xy;
    t0 = cyc; g = -1; r = -1; e = -1; s = -1; d = -1; rlow = 0;
    og = 1'b0; gsel = 1'b0; dp = 1'b0; de = 1'b0; drx = '0; dry = '0; dul = '0;
    lat = v.lat;
    if (drive) begin
      req0 = v.r0; req1 = v.r1; l0 = v.l0; l1 = v.l1;
    end
    for (int k = 0; k < v.lat + 40 && d < 0; k++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && g < 0) g = cyc;
      if (!u_rst_b) begin
        rlow++;
        if (r < 0) r = cyc;
      end
      if (u_en && e < 0) e = cyc;
      if (u_sign && e >= 0 && s < 0) s = cyc;
      if (v.port ? gnt0 : gnt1) og = 1'b1;
      if (done0 || done1) begin
        d = cyc; dp = done1; de = err; drx = rx; dry = ry; dul = u_l;
        gsel = v.port ? gnt1 : gnt0;
      end
    end
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL %s done: got none within %0d cycles expected a done pulse", nm, v.lat + 40);
      return;
    end
    xl = v.port ? v.l1 : v.l0;
    xx = v.port ? x0_1 : x0_0;
    xy = v.port ? y0_1 : y0_0;
    chk_b({nm, " port"}, dp, v.port);
    chk_b({nm, " err"}, de, 1'b0);
    chk_w({nm, " rx"}, drx, fx(xl, xx));
    chk_w({nm, " ry"}, dry, fy(xl, xy));
    chk_w({nm, " u_l"}, dul, xl);
    chk_b({nm, " gnt_at_done"}, gsel, 1'b1);
    chk_b({nm, " other_gnt"}, og, 1'b0);
    chk_i({nm, " gnt_cycle"}, g, t0 + goff);
    chk_i({nm, " rst_cycle"}, r, g);
    chk_i({nm, " rst_len"}, rlow, 1);
    chk_i({nm, " en_cycle"}, e, g + 1);
    chk_i({nm, " sign_cycle"}, s, e + v.lat + 1);
    chk_i({nm, " done_cycle"}, d, s + 1);
  endtask

  task automatic idle_after(input string nm);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk_b({nm, " idle_quiet"}, gnt0 | gnt1 | done0 | done1, 1'b0);
  endtask

  // Job on the short-watchdog instance; u_sign driven by hand sign_at cycles after start (0 = never).
  task automatic run_t(input int sign_at, input logic [W-1:0] x1v, input logic [W-1:0] y1v,
                       input logic exp_err, input logic [W-1:0] exp_rx, input logic [W-1:0] exp_ry,
                       input int exp_doff, input string nm);
    int e, d, rlow;
    bit stray;
    e = -1; d = -1; rlow = 0; stray = 1'b0;
    req0_t = 1'b1;
    for (int k = 0; k < 200 && d < 0; k++) begin
      @(negedge clk);
      if (!u_rst_b_t) rlow++;
      if (gnt1_t || done1_t) stray = 1'b1;
      if (u_en_t && e < 0) e = cyc;
      if (e >= 0 && sign_at > 0 && cyc == e + sign_at) begin
        u_sign_t = 1'b1; u_x1_t = x1v; u_y1_t = y1v;
      end
      if (done0_t) begin
        d = cyc;
        chk_b({nm, " err"}, err_t, exp_err);
        chk_w({nm, " rx"}, rx_t, exp_rx);
        chk_w({nm, " ry"}, ry_t, exp_ry);
        chk_w({nm, " u_x0"}, u_x0_t, x0_0);
        chk_w({nm, " u_y0"}, u_y0_t, y0_0);
        chk_w({nm, " u_l"}, u_l_t, l0);
        chk_b({nm, " gnt"}, gnt0_t, 1'b1);
      end
    end
    req0_t = 1'b0; u_sign_t = 1'b0;
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL %s done: got none within 200 cycles expected a done pulse", nm);
      return;
    end
    chk_i({nm, " done_cycle"}, d, e + exp_doff);
    chk_i({nm, " rst_len"}, rlow, 1);
    chk_b({nm, " port1_quiet"}, stray, 1'b0);
  endtask

  vec_t tbl[8];
  vec_t hv;
  bit   dn;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 256'd7,  256'd9,  10,   1'b0};
    tbl[1] = '{1'b1, 1'b1, 256'd11, 256'd13, 3,    1'b1};
    tbl[2] = '{1'b1, 1'b1, 256'd2,  256'd4,  1,    1'b0};
    tbl[3] = '{1'b0, 1'b1, 256'd6,  256'd8,  5,    1'b1};
    tbl[4] = '{1'b0, 1'b1, 256'd3,  256'd3,  4,    1'b1};
    tbl[5] = '{1'b1, 1'b1, 256'd17, 256'd19, 7,    1'b0};
    tbl[6] = '{1'b1, 1'b0, 256'd5,  256'd0,  1000, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 256'd23, 256'd29, 2,    1'b1};

    rst_b = 1'b0; req0 = 1'b0; req1 = 1'b0; l0 = '0; l1 = '0;
    x0_0 = GX; y0_0 = GY; x0_1 = PX1; y0_1 = PY1;
    req0_t = 1'b0; u_sign_t = 1'b0; u_x1_t = '0; u_y1_t = '0;
    repeat (3) @(negedge clk);
    chk_b("rst u_rst_b_low", u_rst_b, 1'b0);
    chk_b("rst gnt", gnt0 | gnt1, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    chk_b("rst u_rst_b_high", u_rst_b, 1'b1);
    chk_b("rst done_err_en", done0 | done1 | err | u_en, 1'b0);
    chk_w("rst rx", rx, '0);
    chk_w("rst u_l", u_l, '0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], 1'b1, 1, $sformatf("vec%0d", i));
      idle_after($sformatf("vec%0d", i));
    end

    // Port 1 holds its request across two jobs; the second must not see the first's sticky done.
    hv = '{1'b0, 1'b1, 256'd0, 256'd21, 6, 1'b1};
    run_vec(hv, 1'b1, 1, "held_a");
    hv.lat = 9;
    run_vec(hv, 1'b0, 2, "held_b");
    idle_after("held");

    l0 = 256'd5;
    run_t(10, GX, GY, 1'b0, GX, GY, 11, "t_ok");
    @(negedge clk);
    run_t(0, PX1, PY1, 1'b1, GX, GY, 65, "t_expire");
    @(negedge clk);
    run_t(64, PX1, PY1, 1'b0, PX1, PY1, 65, "t_tie");
    @(negedge clk);

    lat = 500; req0 = 1'b1; req1 = 1'b0; l0 = 256'd31;
    repeat (10) @(negedge clk);
    chk_b("mid gnt_before", gnt0, 1'b1);
    rst_b = 1'b0;
    #1;
    chk_b("mid gnt", gnt0 | gnt1, 1'b0);
    chk_b("mid u_rst_b", u_rst_b, 1'b0);
    chk_b("mid u_en_err", u_en | err, 1'b0);
    chk_w("mid rx", rx, '0);
    chk_w("mid u_l", u_l, '0);
    req0 = 1'b0;
    dn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) dn = 1'b1;
    end
    rst_b = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1 || gnt0 || gnt1) dn = 1'b1;
    end
    chk_b("mid no_done", dn, 1'b0);
    chk_b("mid u_rst_b_rel", u_rst_b, 1'b1);
    hv = '{1'b1, 1'b1, 256'd37, 256'd41, 8, 1'b0};
    run_vec(hv, 1'b1, 1, "post_rst");
    idle_after("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
